// File: rtl/keypad_pkg.sv
// Shared constants, FSM encoding and row-strobe helper for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int KP_ROWS     = 4;
  localparam int KP_COLS     = 4;
  localparam int KP_KEYS     = 16;
  localparam int SYNC_STAGES = 2;

  typedef enum logic {
    S_SETTLE = 1'b0,
    S_EVAL   = 1'b1
  } kp_state_e;

  // Active-low strobe pattern with only the selected row pulled low.
  function automatic logic [KP_ROWS-1:0] row_strobe(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for the asynchronous, active-low column lines.
module keypad_sync2
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] stage_r [SYNC_STAGES];

  // Shift the column sample through the synchronizer chain; idle level is all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_r[i] <= 4'hF;
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// Row-strobing 4x4 keypad scanner with per-key debounce and press/release event strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] keypad_matrix,
  output logic        key_event,
  output logic [3:0]  key_code,
  output logic        key_pressed
);

  // Settling below the synchronizer depth would capture stale column data.
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 3) ? 3 : SETTLE_CYCLES;
  localparam int SW         = $clog2(SETTLE_EFF);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_EFF - 1);
  localparam logic [2:0]    DB_LAST     = 3'(DEBOUNCE_SCANS - 1);

  logic [3:0]         col_sync_s;
  kp_state_e          state_r;
  logic [SW-1:0]      settle_cnt_r;
  logic [1:0]         row_r;
  logic [1:0]         col_r;
  logic [3:0]         cap_r;
  logic [2:0]         cnt_r [KP_KEYS];
  logic [KP_KEYS-1:0] matrix_r;
  logic [3:0]         row_out_r;
  logic               key_event_r;
  logic [3:0]         key_code_r;
  logic               key_pressed_r;

  logic [3:0] key_idx_s;
  logic       cap_bit_s;
  logic       cur_bit_s;
  logic [2:0] cur_cnt_s;

  keypad_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (col_in),
    .q     (col_sync_s)
  );

  assign key_idx_s = {row_r, col_r};
  assign cap_bit_s = cap_r[col_r];
  assign cur_bit_s = matrix_r[key_idx_s];
  assign cur_cnt_s = cnt_r[key_idx_s];

  // Scan FSM: settle a row, capture its columns, then debounce one key per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_SETTLE;
      settle_cnt_r  <= '0;
      row_r         <= 2'd0;
      col_r         <= 2'd0;
      cap_r         <= 4'h0;
      matrix_r      <= 16'h0000;
      row_out_r     <= 4'hF;
      key_event_r   <= 1'b0;
      key_code_r    <= 4'h0;
      key_pressed_r <= 1'b0;
      for (int k = 0; k < KP_KEYS; k++) begin
        cnt_r[k] <= 3'd0;
      end
    end else begin
      key_event_r <= 1'b0;
      case (state_r)
        S_SETTLE: begin
          row_out_r <= row_strobe(row_r);
          if (settle_cnt_r == SETTLE_LAST) begin
            cap_r        <= ~col_sync_s;
            col_r        <= 2'd0;
            settle_cnt_r <= '0;
            state_r      <= S_EVAL;
          end else begin
            settle_cnt_r <= settle_cnt_r + SW'(1);
          end
        end
        S_EVAL: begin
          // A raw value matching the stable state restarts the debounce run.
          if (cap_bit_s == cur_bit_s) begin
            cnt_r[key_idx_s] <= 3'd0;
          end else if (cur_cnt_s == DB_LAST) begin
            matrix_r[key_idx_s] <= cap_bit_s;
            cnt_r[key_idx_s]    <= 3'd0;
            key_event_r         <= 1'b1;
            key_code_r          <= key_idx_s;
            key_pressed_r       <= cap_bit_s;
          end else begin
            cnt_r[key_idx_s] <= cur_cnt_s + 3'd1;
          end
          if (col_r == 2'd3) begin
            row_r     <= row_r + 2'd1;
            row_out_r <= row_strobe(row_r + 2'd1);
            col_r     <= 2'd0;
            state_r   <= S_SETTLE;
          end else begin
            row_out_r <= row_strobe(row_r);
            col_r     <= col_r + 2'd1;
          end
        end
        default: begin
          state_r      <= S_SETTLE;
          settle_cnt_r <= '0;
          col_r        <= 2'd0;
        end
      endcase
    end
  end

  assign row_out       = row_out_r;
  assign keypad_matrix = matrix_r;
  assign key_event     = key_event_r;
  assign key_code      = key_code_r;
  assign key_pressed   = key_pressed_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench: behavioural keypad matrix driving two scanner instances (default and fast parameters).
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic [15:0] keys, keys2;
  logic [3:0]  col_in, col_in2;
  logic [3:0]  row_out, row_out2;
  logic [15:0] keypad_matrix, keypad_matrix2;
  logic        key_event, key_event2;
  logic [3:0]  key_code, key_code2;
  logic        key_pressed, key_pressed2;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int ev_cyc[$];
  int ev_code[$];
  int ev_pr[$];
  int ev2_cyc[$];
  int ev2_code[$];
  int ev2_pr[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Column line pulled low when a pressed key sits on the strobed row.
  function automatic logic [3:0] model_cols(input logic [3:0] rows, input logic [15:0] k);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int cc = 0; cc < 4; cc++) begin
        if (!rows[r] && k[r*4+cc]) c[cc] = 1'b0;
      end
    end
    return c;
  endfunction

  assign col_in  = model_cols(row_out, keys);
  assign col_in2 = model_cols(row_out2, keys2);

  keypad_scanner #(.SETTLE_CYCLES(16), .DEBOUNCE_SCANS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .col_in        (col_in),
    .row_out       (row_out),
    .keypad_matrix (keypad_matrix),
    .key_event     (key_event),
    .key_code      (key_code),
    .key_pressed   (key_pressed)
  );

  keypad_scanner #(.SETTLE_CYCLES(3), .DEBOUNCE_SCANS(1)) dut_fast (
    .clk           (clk),
    .reset         (reset2),
    .col_in        (col_in2),
    .row_out       (row_out2),
    .keypad_matrix (keypad_matrix2),
    .key_event     (key_event2),
    .key_code      (key_code2),
    .key_pressed   (key_pressed2)
  );

  always @(negedge clk) begin
    if (key_event === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_code.push_back(int'(key_code));
      ev_pr.push_back(int'(key_pressed));
    end
    if (key_event2 === 1'b1) begin
      ev2_cyc.push_back(cyc);
      ev2_code.push_back(int'(key_code2));
      ev2_pr.push_back(int'(key_pressed2));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the first negedge where row_out has newly become the target pattern.
  task automatic wait_row(input logic [3:0] target, output int t);
    int n;
    n = 0;
    while (row_out === target && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (row_out !== target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_row_timeout", 32'(n < 200), 32'd1);
    t = cyc;
  endtask

  initial begin
    int t, t0, tr, base, n;

    reset  = 1'b1;
    reset2 = 1'b1;
    keys   = 16'h0000;
    keys2  = 16'h0000;
    wait_cycles(3);
    chk("rst_row_out", 32'(row_out), 32'hF);
    chk("rst_matrix", 32'(keypad_matrix), 32'h0);
    chk("rst_event", 32'(key_event), 32'h0);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_pressed", 32'(key_pressed), 32'h0);

    // Idle scan: row strobe sequence and period.
    reset = 1'b0;
    tr = cyc;
    wait_cycles(1);
    chk("first_row", 32'(row_out), 32'hE);
    wait_row(4'b1101, t);
    chk("first_row_change", 32'(t), 32'(tr + 20));
    wait_cycles(19);
    chk("row1_hold", 32'(row_out), 32'hD);
    wait_cycles(1);
    chk("row2", 32'(row_out), 32'hB);
    wait_cycles(20);
    chk("row3", 32'(row_out), 32'h7);
    wait_cycles(20);
    chk("row0_wrap", 32'(row_out), 32'hE);
    wait_cycles(20);
    chk("row1_again", 32'(row_out), 32'hD);
    chk("idle_matrix", 32'(keypad_matrix), 32'h0);
    chk("idle_events", 32'(ev_code.size()), 32'd0);

    // Key 6 held 6 scans then released.
    wait_row(4'b1101, t0);
    base = ev_code.size();
    keys = 16'h0040;
    wait_cycles(480);
    chk("k6_held_matrix", 32'(keypad_matrix), 32'h0040);
    keys = 16'h0000;
    wait_cycles(480);
    chk("k6_rel_matrix", 32'(keypad_matrix), 32'h0);
    n = ev_code.size() - base;
    chk("k6_event_count", 32'(n), 32'd2);
    if (n >= 2) begin
      chk("k6_press_code", 32'(ev_code[base]), 32'd6);
      chk("k6_press_pr", 32'(ev_pr[base]), 32'd1);
      chk("k6_press_cyc", 32'(ev_cyc[base]), 32'(t0 + 259));
      chk("k6_rel_code", 32'(ev_code[base+1]), 32'd6);
      chk("k6_rel_pr", 32'(ev_pr[base+1]), 32'd0);
      chk("k6_rel_cyc", 32'(ev_cyc[base+1]), 32'(t0 + 739));
    end

    // Bounce: 3 scans pressed, 1 released, 3 pressed, released.
    wait_row(4'b1101, t);
    base = ev_code.size();
    keys = 16'h0040;
    wait_cycles(240);
    chk("bounce_mid1", 32'(keypad_matrix), 32'h0);
    keys = 16'h0000;
    wait_cycles(80);
    keys = 16'h0040;
    wait_cycles(240);
    chk("bounce_mid2", 32'(keypad_matrix), 32'h0);
    keys = 16'h0000;
    wait_cycles(480);
    chk("bounce_matrix", 32'(keypad_matrix), 32'h0);
    chk("bounce_events", 32'(ev_code.size() - base), 32'd0);

    // Whole row 0 pressed together.
    wait_row(4'b1110, t0);
    base = ev_code.size();
    keys = 16'h000F;
    wait_cycles(480);
    chk("row0_matrix", 32'(keypad_matrix), 32'h000F);
    n = ev_code.size() - base;
    chk("row0_event_count", 32'(n), 32'd4);
    if (n >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("row0_code", 32'(ev_code[base+i]), 32'(i));
        chk("row0_pr", 32'(ev_pr[base+i]), 32'd1);
        chk("row0_cyc", 32'(ev_cyc[base+i]), 32'(t0 + 257 + i));
      end
    end

    // Key 15 stable, then reset mid-evaluation and re-debounce.
    reset = 1'b1;
    wait_cycles(2);
    keys  = 16'h8000;
    reset = 1'b0;
    n = 0;
    while (keypad_matrix !== 16'h8000 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("k15_settle", 32'(keypad_matrix), 32'h8000);
    wait_row(4'b0111, t);
    wait_cycles(17);
    base = ev_code.size();
    reset = 1'b1;
    wait_cycles(1);
    chk("k15_rst_matrix", 32'(keypad_matrix), 32'h0);
    chk("k15_rst_row", 32'(row_out), 32'hF);
    chk("k15_rst_event", 32'(key_event), 32'h0);
    wait_cycles(1);
    chk("k15_rst2_row", 32'(row_out), 32'hF);
    reset = 1'b0;
    tr = cyc;
    wait_cycles(330);
    n = ev_code.size() - base;
    chk("k15_event_count", 32'(n), 32'd1);
    if (n >= 1) begin
      chk("k15_code", 32'(ev_code[base]), 32'd15);
      chk("k15_pr", 32'(ev_pr[base]), 32'd1);
      chk("k15_cyc", 32'(ev_cyc[base]), 32'(tr + 320));
    end
    chk("k15_matrix", 32'(keypad_matrix), 32'h8000);

    // Fast instance: 7-cycle rows, single-scan debounce, key 9.
    keys2 = 16'h0200;
    wait_cycles(2);
    reset2 = 1'b0;
    tr = cyc;
    wait_cycles(6);
    chk("fast_row0", 32'(row_out2), 32'hE);
    wait_cycles(1);
    chk("fast_row1", 32'(row_out2), 32'hD);
    wait_cycles(6);
    chk("fast_row1_hold", 32'(row_out2), 32'hD);
    wait_cycles(1);
    chk("fast_row2", 32'(row_out2), 32'hB);
    wait_cycles(16);
    n = ev2_code.size();
    chk("fast_event_count", 32'(n), 32'd1);
    if (n >= 1) begin
      chk("fast_code", 32'(ev2_code[0]), 32'd9);
      chk("fast_pr", 32'(ev2_pr[0]), 32'd1);
      chk("fast_cyc", 32'(ev2_cyc[0]), 32'(tr + 19));
    end
    chk("fast_matrix", 32'(keypad_matrix2), 32'h0200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the physical 4x4 hex keypad and replaces the constant-zero keypad_matrix feeding the cpu keypad_matrix input.
- Strobes one row at a time and samples the four columns through a synchronizer.
- Debounces each of the 16 keys independently.
- Publishes a stable 16-bit pressed-key vector plus a one-cycle press/release event strobe.
- Sits between the keypad pins at the top level and the cpu keypad_matrix input.

Parameters:
- SETTLE_CYCLES, default 16: cycles a row is driven before its columns are captured. Minimum 3, which covers the synchronizer delay; values below 3 are treated as 3.
- DEBOUNCE_SCANS, default 4: consecutive scans with an unchanged raw value needed before a key's stable state flips. Range 1..7.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- col_in  input  4  keypad column lines, asynchronous, active-low (0 = pressed key on the driven row)
- row_out  output  4  row strobes, active-low, at most one bit low
- keypad_matrix  output  16  debounced key state; bit index = row*4 + col; 1 = pressed
- key_event  output  1  one-cycle pulse when a key's debounced state changes
- key_code  output  4  index (row*4 + col) of the changing key; valid while key_event = 1
- key_pressed  output  1  1 = press, 0 = release; valid while key_event = 1

Behaviour:
- Reset (synchronous, active-high):
  - row_out = 4'hF, keypad_matrix = 0, key_event = 0, key_code = 0, key_pressed = 0.
  - All debounce counters = 0; synchronizer flops = 4'hF.
  - row index = 0, state = S_SETTLE, settle count = 0.
- Synchronizer: col_in passes through 2 flops to give col_sync. The raw pressed value for a column is ~col_sync[c].
- Row drive: row_out = ~(1 << row) in every non-reset cycle. The first cycle after reset deasserts drives 4'b1110.
- FSM, S_SETTLE:
  - The settle counter counts 0..SETTLE_CYCLES-1.
  - On the last count, capture ~col_sync into cap[3:0] and go to S_EVAL with col = 0.
- FSM, S_EVAL (4 cycles, col = 0..3): evaluate key k = row*4 + col, one key per cycle.
  - If cap[col] equals keypad_matrix[k]: clear cnt[k].
  - Else, if cnt[k] equals DEBOUNCE_SCANS-1: toggle keypad_matrix[k], clear cnt[k], and register an event (key_event = 1, key_code = k, key_pressed = new state). The outputs appear on the cycle after evaluation.
  - Else: increment cnt[k].
  - After col = 3: row = row + 1 modulo 4 (3 wraps to 0), state = S_SETTLE.
- Timing:
  - Row period = SETTLE_CYCLES + 4 cycles; full scan = 4 × row period (80 cycles at defaults).
  - At most one event per cycle by construction.
  - key_event is low in every cycle without an event. key_code and key_pressed hold their last values when key_event = 0.
- Debounce latency: a change is committed at the DEBOUNCE_SCANS-th consecutive scan that differs from the stable value. Any intermediate scan that matches the stable value restarts the count.
- Multiple keys are independent. Phantom keys from matrix ghosting are not suppressed; the cpu treats the vector as truth.
- Several keys changing on the same row produce events on consecutive cycles in ascending col order.
- Reset mid-scan: a synchronous return to the reset state. No event is emitted in the reset cycle. Keys held across reset are re-debounced from zero and produce fresh press events.
- Counter width: 3 bits per key; cnt array = 16 × 3 bits.

Decomposition:
- Shared package keypad_pkg:
  - KP_ROWS = 4, KP_COLS = 4, KP_KEYS = 16.
  - FSM state encoding S_SETTLE = 1'b0, S_EVAL = 1'b1.
  - Constant SYNC_STAGES = 2.
- One sub-module, keypad_sync2: a 4-bit two-flop synchronizer with synchronous reset to 4'hF.
- Debounce array and FSM stay in keypad_scanner.

Test Plan:
- Reset, then idle with col_in = 4'hF -> row_out sequence 1110, 1101, 1011, 0111 with 20 cycles each, repeating every 80 cycles; keypad_matrix = 0; key_event never asserted.
- Bench matrix model holds key row 1 / col 2 for 6 scans, then releases -> exactly one event (code 6, pressed 1) during scan 4, keypad_matrix = 16'h0040; after release, one event (code 6, pressed 0) 4 scans later, keypad_matrix = 0.
- Bounce: key 6 pressed for 3 scans, released 1 scan, pressed 3 scans, released -> no events; keypad_matrix stays 0.
- Keys 0..3 (row 0) pressed together and held -> four events with codes 0, 1, 2, 3 on consecutive cycles, all pressed = 1; keypad_matrix = 16'h000F.
- Key 15 held until keypad_matrix = 16'h8000, then reset asserted for 2 cycles mid-S_EVAL -> keypad_matrix = 0 and row_out = 4'hF during reset; a new press event for code 15 follows 4 scans after release of reset.
- Parameters SETTLE_CYCLES = 3, DEBOUNCE_SCANS = 1, key 9 pressed -> row period 7 cycles; press event code 9 occurs on the first scan of row 2.
